// File: rtl/pulse_pkg.sv
// Shared types and width helpers for the SPGD pulse metric accumulator.
package pulse_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE_A = 3'd1,
    ACC_A    = 3'd2,
    WAIT_B   = 3'd3,
    SETTLE_B = 3'd4,
    ACC_B    = 3'd5
  } pulse_state_e;

  // Accumulator width: a full-scale sample times the maximum count cannot overflow it.
  function automatic int acc_width(input int adc_w, input int cnt_w);
    return adc_w + cnt_w;
  endfunction

endpackage

// File: rtl/pulse_phase_acc.sv
// One perturbation window: settle-sample discard, saturating sample counter and
// sign-extended accumulator, cleared between pairs.
module pulse_phase_acc import pulse_pkg::*; #(
  parameter int ADC_WIDTH = 14,
  parameter int CNT_WIDTH = 12,
  parameter int SKIP      = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                clr,
  input  logic                                en,
  input  logic signed [ADC_WIDTH-1:0]         adc_data,
  output logic signed [ADC_WIDTH+CNT_WIDTH-1:0] sum,
  output logic [CNT_WIDTH-1:0]                count,
  output logic                                sat,
  output logic                                settled
);

  localparam int ACC_WIDTH = acc_width(ADC_WIDTH, CNT_WIDTH);
  localparam logic [CNT_WIDTH-1:0] SKIP_C  = CNT_WIDTH'(SKIP);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0]        skip_cnt_r;
  logic [CNT_WIDTH-1:0]        count_r;
  logic signed [ACC_WIDTH-1:0] sum_r;
  logic                        sat_r;
  logic                        skip_done_s;
  logic [CNT_WIDTH:0]          skip_nxt_s;
  logic signed [ACC_WIDTH-1:0] adc_ext_s;

  assign skip_done_s = (skip_cnt_r >= SKIP_C);
  assign skip_nxt_s  = {1'b0, skip_cnt_r} + {{CNT_WIDTH{1'b0}}, 1'b1};
  // High when the current enabled edge completes (or has completed) the settle phase.
  assign settled     = skip_done_s || (skip_nxt_s >= {1'b0, SKIP_C});
  assign adc_ext_s   = {{CNT_WIDTH{adc_data[ADC_WIDTH-1]}}, adc_data};

  assign sum   = sum_r;
  assign count = count_r;
  assign sat   = sat_r;

  // Settle counting, then saturating accumulation of enabled samples.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      skip_cnt_r <= {CNT_WIDTH{1'b0}};
      count_r    <= {CNT_WIDTH{1'b0}};
      sum_r      <= {ACC_WIDTH{1'b0}};
      sat_r      <= 1'b0;
    end else if (en) begin
      if (!skip_done_s) begin
        skip_cnt_r <= skip_cnt_r + CNT_ONE;
      end else if (count_r == CNT_MAX) begin
        sat_r <= 1'b1;
      end else begin
        sum_r   <= sum_r + adc_ext_s;
        count_r <= count_r + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/pulse_metric_acc.sv
// Pair FSM, protocol checking and published result registers for the SPGD
// receive path; one pulse_phase_acc per perturbation window.
module pulse_metric_acc import pulse_pkg::*; #(
  parameter int ADC_WIDTH = 14,
  parameter int CNT_WIDTH = 12,
  parameter int SKIP      = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  A,
  input  logic                                  B,
  input  logic signed [ADC_WIDTH-1:0]           adc_data,
  output logic signed [ADC_WIDTH+CNT_WIDTH-1:0] sum_a,
  output logic signed [ADC_WIDTH+CNT_WIDTH-1:0] sum_b,
  output logic [CNT_WIDTH-1:0]                  count_a,
  output logic [CNT_WIDTH-1:0]                  count_b,
  output logic signed [ADC_WIDTH+CNT_WIDTH:0]   diff,
  output logic                                  valid,
  output logic                                  sat,
  output logic                                  err
);

  localparam int ACC_WIDTH = acc_width(ADC_WIDTH, CNT_WIDTH);

  pulse_state_e state_r, state_s;
  logic en_a_s, en_b_s, err_s, pub_s, clr_s;
  logic settled_a_s, settled_b_s, sat_a_s, sat_b_s;
  logic blocked_r;
  logic signed [ACC_WIDTH-1:0] acc_a_s, acc_b_s;
  logic [CNT_WIDTH-1:0]        cnt_a_s, cnt_b_s;

  logic signed [ACC_WIDTH-1:0] sum_a_r, sum_b_r;
  logic [CNT_WIDTH-1:0]        count_a_r, count_b_r;
  logic signed [ACC_WIDTH:0]   diff_r;
  logic                        valid_r, sat_r, err_r;

  assign clr_s = err_s || pub_s;

  pulse_phase_acc #(.ADC_WIDTH(ADC_WIDTH), .CNT_WIDTH(CNT_WIDTH), .SKIP(SKIP)) u_acc_a (
    .clk(clk), .rst(rst), .clr(clr_s), .en(en_a_s), .adc_data(adc_data),
    .sum(acc_a_s), .count(cnt_a_s), .sat(sat_a_s), .settled(settled_a_s)
  );

  pulse_phase_acc #(.ADC_WIDTH(ADC_WIDTH), .CNT_WIDTH(CNT_WIDTH), .SKIP(SKIP)) u_acc_b (
    .clk(clk), .rst(rst), .clr(clr_s), .en(en_b_s), .adc_data(adc_data),
    .sum(acc_b_s), .count(cnt_b_s), .sat(sat_b_s), .settled(settled_b_s)
  );

  // Next-state, window enables, protocol errors and publish request.
  always_comb begin
    state_s = state_r;
    en_a_s  = 1'b0;
    en_b_s  = 1'b0;
    err_s   = 1'b0;
    pub_s   = 1'b0;
    case (state_r)
      IDLE: begin
        // A stuck high across an error must drop before a new pair may start.
        if (A && !blocked_r) begin
          en_a_s  = 1'b1;
          state_s = settled_a_s ? ACC_A : SETTLE_A;
        end else begin
          state_s = IDLE;
        end
      end
      SETTLE_A, ACC_A: begin
        if (A && B) begin
          err_s   = 1'b1;
          state_s = IDLE;
        end else if (A) begin
          en_a_s  = 1'b1;
          state_s = settled_a_s ? ACC_A : SETTLE_A;
        end else begin
          state_s = WAIT_B;
        end
      end
      WAIT_B: begin
        if (A) begin
          err_s   = 1'b1;
          state_s = IDLE;
        end else if (B) begin
          en_b_s  = 1'b1;
          state_s = settled_b_s ? ACC_B : SETTLE_B;
        end else begin
          state_s = WAIT_B;
        end
      end
      SETTLE_B, ACC_B: begin
        if (A) begin
          err_s   = 1'b1;
          state_s = IDLE;
        end else if (B) begin
          en_b_s  = 1'b1;
          state_s = settled_b_s ? ACC_B : SETTLE_B;
        end else begin
          pub_s   = 1'b1;
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, strobes, error blocking and the published result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      blocked_r <= 1'b0;
      valid_r   <= 1'b0;
      err_r     <= 1'b0;
      sat_r     <= 1'b0;
      sum_a_r   <= {ACC_WIDTH{1'b0}};
      sum_b_r   <= {ACC_WIDTH{1'b0}};
      count_a_r <= {CNT_WIDTH{1'b0}};
      count_b_r <= {CNT_WIDTH{1'b0}};
      diff_r    <= {(ACC_WIDTH+1){1'b0}};
    end else begin
      state_r <= state_s;
      valid_r <= pub_s;
      err_r   <= err_s;
      if (err_s && A) begin
        blocked_r <= 1'b1;
      end else if (!A) begin
        blocked_r <= 1'b0;
      end
      if (pub_s) begin
        sum_a_r   <= acc_a_s;
        sum_b_r   <= acc_b_s;
        count_a_r <= cnt_a_s;
        count_b_r <= cnt_b_s;
        sat_r     <= sat_a_s || sat_b_s;
        diff_r    <= {acc_a_s[ACC_WIDTH-1], acc_a_s} - {acc_b_s[ACC_WIDTH-1], acc_b_s};
      end
    end
  end

  assign sum_a   = sum_a_r;
  assign sum_b   = sum_b_r;
  assign count_a = count_a_r;
  assign count_b = count_b_r;
  assign diff    = diff_r;
  assign valid   = valid_r;
  assign sat     = sat_r;
  assign err     = err_r;

endmodule

// File: tb/tb_pulse_metric_acc.sv
// Directed bench for pulse_metric_acc: a CNT_WIDTH=12 instance and a CNT_WIDTH=4
// instance share stimulus; expected values are hand-computed constants.
module tb_pulse_metric_acc;

  logic clk = 1'b0;
  logic rst, A, B;
  logic signed [13:0] adc;

  logic signed [25:0] sum_a, sum_b;
  logic [11:0]        count_a, count_b;
  logic signed [26:0] diff;
  logic               valid, sat, err;

  logic signed [17:0] s_sum_a, s_sum_b;
  logic [3:0]         s_count_a, s_count_b;
  logic signed [18:0] s_diff;
  logic               s_valid, s_sat, s_err;

  int n_checks = 0;
  int n_err    = 0;
  int vcnt     = 0;
  int ecnt     = 0;
  int vbase, ebase;

  pulse_metric_acc #(.ADC_WIDTH(14), .CNT_WIDTH(12), .SKIP(2)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .adc_data(adc),
    .sum_a(sum_a), .sum_b(sum_b), .count_a(count_a), .count_b(count_b),
    .diff(diff), .valid(valid), .sat(sat), .err(err)
  );

  pulse_metric_acc #(.ADC_WIDTH(14), .CNT_WIDTH(4), .SKIP(2)) dut_s (
    .clk(clk), .rst(rst), .A(A), .B(B), .adc_data(adc),
    .sum_a(s_sum_a), .sum_b(s_sum_b), .count_a(s_count_a), .count_b(s_count_b),
    .diff(s_diff), .valid(s_valid), .sat(s_sat), .err(s_err)
  );

  always #5 clk = ~clk;

  // Strobe counters for the main instance, sampled away from the active edge.
  always @(negedge clk) begin
    if (valid) vcnt++;
    if (err) ecnt++;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic a, input logic b, input int d, input int n);
    A   = a;
    B   = b;
    adc = 14'(d);
    tick(n);
  endtask

  task automatic check_pair(input string tag, input longint ca, input longint sa,
                            input longint cb, input longint sb, input longint df);
    check({tag, " valid"},   valid,   1);
    check({tag, " count_a"}, count_a, ca);
    check({tag, " sum_a"},   sum_a,   sa);
    check({tag, " count_b"}, count_b, cb);
    check({tag, " sum_b"},   sum_b,   sb);
    check({tag, " diff"},    diff,    df);
  endtask

  initial begin
    rst = 1'b1; A = 1'b0; B = 1'b0; adc = 14'sd0;
    tick(3);
    check("rst sum_a", sum_a, 0);
    check("rst diff",  diff,  0);
    check("rst valid", valid, 0);
    check("rst sat",   sat,   0);
    check("rst err",   err,   0);
    rst = 1'b0;
    tick(2);

    // Nominal pair
    vbase = vcnt;
    drive(1'b1, 1'b0, 100, 10);
    drive(1'b0, 1'b0, 0, 5);
    drive(1'b0, 1'b1, -50, 10);
    check("nom valid early", valid, 0);
    drive(1'b0, 1'b0, 0, 1);
    check_pair("nom", 8, 800, 8, -400, 1200);
    check("nom sat", sat, 0);
    tick(1);
    check("nom valid drop", valid, 0);
    check("nom strobes", vcnt - vbase, 1);

    // Window shorter than SKIP
    drive(1'b1, 1'b0, 7, 2);
    drive(1'b0, 1'b0, 0, 2);
    drive(1'b0, 1'b1, 3, 6);
    drive(1'b0, 1'b0, 0, 1);
    check_pair("short", 0, 0, 4, 12, -12);
    tick(2);

    // A/B overlap in ACC_A
    vbase = vcnt; ebase = ecnt;
    drive(1'b1, 1'b0, 5, 5);
    drive(1'b1, 1'b1, 5, 1);
    check("ovl err", err, 1);
    check("ovl valid", valid, 0);
    drive(1'b0, 1'b0, 0, 1);
    check("ovl err drop", err, 0);
    drive(1'b0, 1'b0, 0, 3);
    check("ovl diff held", diff, -12);
    check("ovl sum_b held", sum_b, 12);
    check("ovl err strobes", ecnt - ebase, 1);
    check("ovl no valid", vcnt - vbase, 0);

    // A re-asserted in WAIT_B; A held high must not start a new pair
    vbase = vcnt; ebase = ecnt;
    drive(1'b1, 1'b0, 5, 4);
    drive(1'b0, 1'b0, 0, 2);
    drive(1'b1, 1'b0, 5, 1);
    check("waitb err", err, 1);
    drive(1'b1, 1'b0, 5, 3);
    drive(1'b0, 1'b1, 9, 4);
    drive(1'b0, 1'b0, 0, 3);
    check("waitb err strobes", ecnt - ebase, 1);
    check("waitb no valid", vcnt - vbase, 0);
    check("waitb diff held", diff, -12);

    // Orphan B in IDLE
    vbase = vcnt; ebase = ecnt;
    drive(1'b0, 1'b1, 11, 5);
    drive(1'b0, 1'b0, 0, 3);
    check("orphan no valid", vcnt - vbase, 0);
    check("orphan no err", ecnt - ebase, 0);

    // Reset in ACC_B, then a clean pair
    vbase = vcnt; ebase = ecnt;
    drive(1'b1, 1'b0, 10, 6);
    drive(1'b0, 1'b0, 0, 1);
    drive(1'b0, 1'b1, 20, 4);
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 1);
    rst = 1'b0;
    check("rstmid diff", diff, 0);
    check("rstmid count_b", count_b, 0);
    check("rstmid sum_b", sum_b, 0);
    check("rstmid valid", valid, 0);
    drive(1'b1, 1'b0, 10, 6);
    drive(1'b0, 1'b0, 0, 1);
    drive(1'b0, 1'b1, 20, 6);
    drive(1'b0, 1'b0, 0, 1);
    check_pair("post rst", 4, 40, 4, 80, -40);
    tick(1);
    check("post rst strobes", vcnt - vbase, 1);
    check("post rst no err", ecnt - ebase, 0);

    // Back-to-back pairs: A rises on the edge after the publishing edge
    vbase = vcnt;
    drive(1'b1, 1'b0, 3, 5);
    drive(1'b0, 1'b0, 0, 1);
    drive(1'b0, 1'b1, 1, 5);
    drive(1'b0, 1'b0, 0, 1);
    check_pair("b2b1", 3, 9, 3, 3, 6);
    drive(1'b1, 1'b0, -2, 7);
    drive(1'b0, 1'b0, 0, 1);
    drive(1'b0, 1'b1, 4, 4);
    drive(1'b0, 1'b0, 0, 1);
    check_pair("b2b2", 5, -10, 2, 8, -18);
    tick(1);
    check("b2b strobes", vcnt - vbase, 2);

    // Negative extreme sample
    drive(1'b1, 1'b0, -8192, 102);
    drive(1'b0, 1'b0, 0, 1);
    drive(1'b0, 1'b1, 0, 3);
    drive(1'b0, 1'b0, 0, 1);
    check_pair("negx", 100, -819200, 1, 0, -819200);
    tick(2);

    // Saturation on the CNT_WIDTH=4 instance
    rst = 1'b1;
    drive(1'b0, 1'b0, 0, 2);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1000, 30);
    drive(1'b0, 1'b0, 0, 1);
    drive(1'b0, 1'b1, 0, 5);
    drive(1'b0, 1'b0, 0, 1);
    check("sat4 valid",   s_valid,   1);
    check("sat4 count_a", s_count_a, 15);
    check("sat4 sum_a",   s_sum_a,   15000);
    check("sat4 count_b", s_count_b, 3);
    check("sat4 sat",     s_sat,     1);
    check("sat4 diff",    s_diff,    15000);
    check_pair("sat12", 28, 28000, 3, 0, 28000);
    check("sat12 sat", sat, 0);
    drive(1'b1, 1'b0, 1, 4);
    drive(1'b0, 1'b0, 0, 1);
    drive(1'b0, 1'b1, 1, 4);
    drive(1'b0, 1'b0, 0, 1);
    check("sat4 clear sat",  s_sat,     0);
    check("sat4 clear cnt",  s_count_a, 2);
    check("sat4 clear diff", s_diff,    0);

    tick(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/pulse_metric_acc.md
# pulse_metric_acc

Receive side of the SPGD pulse perturbation path. `pulse_FSM` drives the +/- perturbation windows (A, B). This block takes those same phase flags plus the signed ADC metric stream on the ADC clock. For each window it discards settling samples and accumulates the rest. After each A-then-B pair it reports the sums, sample counts and the gradient difference sum_a − sum_b to the SPGD update logic.

## Interface
Parameters:
- ADC_WIDTH, 14, signed ADC sample width.
- CNT_WIDTH, 12, per-phase sample counter width; max count 2^CNT_WIDTH−1.
- SKIP, 4, settling samples discarded at the start of each window (0 allowed, < 2^CNT_WIDTH).

Ports:
- clk  in  1  ADC clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- A  in  1  phase-A (+ perturbation) window flag, synchronous to clk.
- B  in  1  phase-B (− perturbation) window flag, synchronous to clk.
- adc_data  in  ADC_WIDTH  signed metric sample, valid every cycle.
- sum_a, sum_b  out  ADC_WIDTH+CNT_WIDTH  signed window sums.
- count_a, count_b  out  CNT_WIDTH  accumulated sample counts.
- diff  out  ADC_WIDTH+CNT_WIDTH+1  signed sum_a − sum_b.
- valid  out  1  one-cycle strobe: outputs hold a new result.
- sat  out  1  sticky: a counter saturated in the last reported pair.
- err  out  1  one-cycle strobe: protocol violation, pair discarded.

## Operation
- States:
  - IDLE: wait for A=1. B=1 in IDLE is ignored (orphan B).
  - SETTLE_A: discard samples until SKIP samples are seen while A=1. SETTLE_A goes directly to ACC_A when SKIP=0.
  - ACC_A: add adc_data each cycle A=1.
  - WAIT_B: wait for B=1.
  - SETTLE_B / ACC_B: same as the A states, using B.
  - The first cycle with the window flag 0 ends the window: SETTLE_A/ACC_A → WAIT_B, SETTLE_B/ACC_B → IDLE with result publish.
- A window shorter than SKIP gives count 0 and sum 0, and is still a valid window.
- Accumulation is sign-extended and full width, with no overflow possible within the count bound.
- At count = 2^CNT_WIDTH−1, further samples in that window are dropped, the count holds, and the internal saturation flag is set.
- Protocol errors:
  - A=1 and B=1 in the same cycle in any non-IDLE state.
  - A=1 during WAIT_B/SETTLE_B/ACC_B.
  - On an error: err=1 next cycle, go to IDLE, internal sums cleared, published outputs untouched.
  - If A=1 coincides with the error, the new A window is not started until A is seen low and then high again.
- Publish: sum_a, sum_b, count_a, count_b, diff and sat are registered together, with valid=1. They hold until the next publish.
- Reset: all outputs 0, state IDLE, accumulators 0. Reset mid-window abandons the pair with no valid and no err.

## Timing
- All inputs are sampled on the rising edge of clk. Each edge with the flag high and the state in ACC counts one sample of adc_data from that same edge.
- Settle: the first SKIP edges with the flag high are discarded.
- Result: valid is high for the cycle following the edge that first samples B=0 in SETTLE_B/ACC_B. Latency is 1 cycle from the end of the B window.
- err is high for the one cycle following the offending edge.
- A new A window may start on the edge immediately after the publishing edge. Back-to-back pairs lose no samples.
- diff is computed from the final sums and is consistent with sum_a/sum_b in the valid cycle.

## Structure
- Shared package `pulse_pkg`: state enum (IDLE, SETTLE_A, ACC_A, WAIT_B, SETTLE_B, ACC_B) and derived width constants (ACC_WIDTH = ADC_WIDTH+CNT_WIDTH).
- One sub-module, `pulse_phase_acc`: settle counter, saturating sample counter and accumulator with clear/enable. Instantiate it twice (A, B). The top holds the FSM, error detection and output registers.

## Test plan
SKIP=2, CNT_WIDTH=12 unless noted.
- Nominal pair: A high 10 cycles with adc=100, then 5 idle cycles, then B high 10 cycles with adc=−50 → count_a=8, sum_a=800, count_b=8, sum_b=−400, diff=1200, valid for exactly 1 cycle, 1 cycle after B falls.
- Short window: A high 2 cycles (adc=7), B high 6 cycles (adc=3) → count_a=0, sum_a=0, count_b=4, sum_b=12, diff=−12.
- Saturation, CNT_WIDTH=4: A high 30 cycles with adc=1000, then B high 5 cycles with adc=0 → count_a=15, sum_a=15000, sat=1, diff=15000.
- Protocol errors:
  - A and B overlap for one cycle during ACC_A → err pulse, no valid, previous outputs unchanged.
  - A re-asserted in WAIT_B → err.
  - Orphan B in IDLE → no response.
- Reset mid-ACC_B: rst for 1 cycle → all outputs 0, no valid. The next clean pair (adc A=10, B=20, 6 cycles each) gives diff=−40.
- Back-to-back: two pairs where B falls and A rises on the next edge → two valid strobes, second pair counts exact. Also a negative-extreme case: adc=−8192 for 100 accumulated samples gives sum=−819200.
